// File: rtl/grid_display_pkg.sv
// Shared types and helpers for the 8x8 LED matrix scanner.
package grid_display_pkg;
  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int GRID_BITS = 64;

  typedef logic [2:0] row_idx_t;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} scan_state_t;

  // Row r occupies grid[8r+7:8r]; column c is bit 8r+c.
  function automatic logic [GRID_COLS-1:0] row_of(input logic [GRID_BITS-1:0] g,
                                                  input row_idx_t idx);
    return g[{idx, 3'b000} +: GRID_COLS];
  endfunction
endpackage

// File: rtl/grid_display_scan_popcount64.sv
// Combinational 64-bit population count built as a balanced adder tree.
module popcount64 (
  input  logic [63:0] din,
  output logic [6:0]  cnt
);
  logic [31:0][1:0] l1;
  logic [15:0][2:0] l2;
  logic [7:0][3:0]  l3;
  logic [3:0][4:0]  l4;
  logic [1:0][5:0]  l5;

  always_comb begin
    for (int i = 0; i < 32; i++) l1[i] = {1'b0, din[2*i]} + {1'b0, din[2*i+1]};
    for (int i = 0; i < 16; i++) l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    for (int i = 0; i < 8; i++)  l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
    for (int i = 0; i < 4; i++)  l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
    for (int i = 0; i < 2; i++)  l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
    cnt = {1'b0, l5[0]} + {1'b0, l5[1]};
  end
endmodule

// File: rtl/grid_display_scan.sv
// Double-buffered row-multiplexed scanner for an 8x8 LED matrix.
// Optional macro SCAN_BLANK_EN inserts a one-cycle blank after every row.
module grid_display_scan
  import grid_display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [GRID_BITS-1:0] grid,
  input  logic                 grid_valid,
  output logic [GRID_ROWS-1:0] row_sel,
  output logic [GRID_COLS-1:0] col_data,
  output logic                 frame_done,
  output logic [6:0]           alive_count,
  output logic                 busy
);
  localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_CYCLES - 1);
  localparam row_idx_t   LAST_ROW     = row_idx_t'(GRID_ROWS - 1);

  scan_state_t          state_q, state_d;
  logic [GRID_BITS-1:0] shadow_q, shadow_d, pending_q, pending_d;
  logic                 pend_flag_q, pend_flag_d;
  row_idx_t             row_q, row_d;
  logic [7:0]           dwell_q, dwell_d;
  logic [6:0]           alive_q, alive_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_end;
  logic [6:0]           shadow_pop;

  popcount64 u_pop (.din(shadow_q), .cnt(shadow_pop));

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    row_d        = row_q;
    dwell_d      = dwell_q;
    alive_d      = alive_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      IDLE: if (grid_valid) begin
        shadow_d = grid;
        state_d  = LOAD;
      end
      LOAD: begin
        alive_d = shadow_pop;
        row_d   = '0;
        dwell_d = DWELL_RELOAD;
        state_d = SCAN;
      end
      SCAN: begin
        if (dwell_q != 8'd0) begin
          dwell_d = dwell_q - 8'd1;
        end else begin
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
`else
          if (row_q != LAST_ROW) begin
            row_d   = row_q + row_idx_t'(1);
            dwell_d = DWELL_RELOAD;
          end else begin
            frame_end = 1'b1;
          end
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (row_q != LAST_ROW) begin
          row_d   = row_q + row_idx_t'(1);
          dwell_d = DWELL_RELOAD;
          state_d = SCAN;
        end else begin
          frame_end = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A strobe landing exactly on frame end bypasses the pending buffer.
    if (frame_end) begin
      frame_done_d = 1'b1;
      if (grid_valid) begin
        shadow_d    = grid;
        pend_flag_d = 1'b0;
        state_d     = LOAD;
      end else if (pend_flag_q) begin
        shadow_d    = pending_q;
        pend_flag_d = 1'b0;
        state_d     = LOAD;
      end else begin
        row_d   = '0;
        dwell_d = DWELL_RELOAD;
        state_d = SCAN;
      end
    end else if (grid_valid && state_q != IDLE) begin
      pending_d   = grid;
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      row_q        <= '0;
      dwell_q      <= '0;
      alive_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      alive_q      <= alive_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_sel     = (state_q == SCAN) ? (GRID_ROWS'(1) << row_q) : '0;
  assign col_data    = (state_q == SCAN) ? row_of(shadow_q, row_q) : '0;
  assign frame_done  = frame_done_q;
  assign alive_count = alive_q;
  assign busy        = (state_q != IDLE);
endmodule
